// File: rtl/attempt_subtract_division_pkg.sv
// Shared types for the free-running restoring divider.
package attempt_subtract_division_pkg;

    typedef enum logic {
        SEQ_LOAD    = 1'b0,
        SEQ_ITERATE = 1'b1
    } seq_state_t;

endpackage

// File: rtl/attempt_subtract_division_div_step.sv
// One restoring attempt-subtract step: shift in a dividend bit, trial-subtract, keep or restore.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bit_in,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    assign shifted = {rem_in, bit_in};
    assign borrow  = shifted < {1'b0, divisor};
    // Only the low bits of the WIDTH+1 difference are ever kept, and they match this narrower subtract.
    assign diff    = shifted[WIDTH-1:0] - divisor;
    assign q_bit   = ~borrow;
    assign rem_out = borrow ? shifted[WIDTH-1:0] : diff;

endmodule

// File: rtl/attempt_subtract_division.sv
// Free-running unsigned restoring divider: one LOAD cycle then WIDTH iterate cycles per pass.
//
// state       | meaning
// SEQ_LOAD    | capture operands, clear working registers, index = WIDTH-1
// SEQ_ITERATE | one attempt-subtract step per cycle, MSB first; publish at index 0
module attempt_subtract_division
    import attempt_subtract_division_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    seq_state_t       state;
    logic [CW-1:0]    idx;
    logic [IW-1:0]    idx_lo;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    assign idx_lo = idx[IW-1:0];

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_r),
        .divisor (dvs_r),
        .bit_in  (dvd_r[idx_lo]),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        quo_next         = quo_r;
        quo_next[idx_lo] = step_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SEQ_LOAD;
            idx       <= '0;
            dvd_r     <= '0;
            dvs_r     <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                SEQ_LOAD: begin
                    dvd_r <= dividend;
                    dvs_r <= divisor;
                    rem_r <= '0;
                    quo_r <= '0;
                    idx   <= LAST_IDX;
                    state <= SEQ_ITERATE;
                end
                SEQ_ITERATE: begin
                    rem_r <= step_rem;
                    quo_r <= quo_next;
                    if (idx == '0) begin
                        // Final step result goes straight to the outputs so no partial value is ever visible.
                        quotient  <= quo_next;
                        remainder <= step_rem;
                        done      <= 1'b1;
                        state     <= SEQ_LOAD;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: state <= SEQ_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_attempt_subtract_division.sv
// Randomised and directed bench for the free-running divider against a pass-level arithmetic model.
module tb_attempt_subtract_division;

    localparam int W    = 16;
    localparam int PASS = W + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] dividend, divisor;
    logic [W-1:0] quotient, remainder;
    logic         done;

    int checks   = 0;
    int failures = 0;

    // Model: operands sampled at each pass start, answer appears PASS edges later.
    int           pos;
    logic [W-1:0] ma, mb, exp_q, exp_r;
    logic         exp_done;

    attempt_subtract_division #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] divide(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == 0) return {{W{1'b1}}, a};
        return {a / b, a % b};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pos = 0; exp_q = '0; exp_r = '0; exp_done = 1'b0; ma = '0; mb = '0;
        end else begin
            exp_done = 1'b0;
            if (pos == 0) begin
                ma = dividend;
                mb = divisor;
            end
            if (pos == PASS - 1) begin
                {exp_q, exp_r} = divide(ma, mb);
                exp_done = 1'b1;
                pos = 0;
            end else begin
                pos = pos + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset !== 1'bx) begin
            chk("cyc_done", 32'(done), 32'(exp_done));
            chk("cyc_quotient", 32'(quotient), 32'(exp_q));
            chk("cyc_remainder", 32'(remainder), 32'(exp_r));
        end
    end

    // Drive new operands at a negedge and require the matching result within two passes.
    task automatic expect_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] eq, input logic [W-1:0] er, input string name);
        bit found = 0;
        dividend = a;
        divisor  = b;
        for (int n = 0; n < 2 * PASS && !found; n++) begin
            @(negedge clk);
            if (done && quotient == eq && remainder == er) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL %s: quotient=%0h remainder=%0h required %0h/%0h within %0d cycles",
                     name, quotient, remainder, eq, er, 2 * PASS);
        end
    endtask

    initial begin
        int last, ndone, n;
        reset    = 1'b1;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk("reset_quotient", 32'(quotient), 32'h0);
        chk("reset_remainder", 32'(remainder), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        reset = 1'b0;

        expect_result(16'h0F00, 16'h0100, 16'h000F, 16'h0000, "div_0f00_0100");
        // Periodicity over ~5000 time units.
        last = -1; ndone = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (done) begin
                if (last >= 0) chk("done_period", 32'(c - last), 32'(PASS));
                last = c;
                ndone++;
            end
        end
        chk("done_count_min", 32'(ndone >= 28), 32'h1);

        expect_result(16'd100, 16'd7, 16'd14, 16'd2, "div_100_7");
        expect_result(16'h1234, 16'h0000, 16'hFFFF, 16'h1234, "div_by_zero");
        expect_result(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, "div_ffff_1");
        expect_result(16'd5, 16'd9, 16'd0, 16'd5, "div_small_big");
        expect_result(16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, "div_equal");

        // Random operands with a mix of divisor ranges, changed at random cycles.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) begin
                dividend = W'($urandom);
                case ($urandom_range(0, 4))
                    0: divisor = '0;
                    1: divisor = W'($urandom_range(1, 15));
                    2: divisor = dividend + W'($urandom_range(1, 100));
                    default: divisor = W'($urandom);
                endcase
            end
        end

        // Mid-pass reset: outputs clear at once, pass aborts, first result comes after a full pass.
        dividend = 16'd100;
        divisor  = 16'd7;
        repeat (PASS + 7) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_quotient", 32'(quotient), 32'h0);
        chk("async_remainder", 32'(remainder), 32'h0);
        chk("async_done", 32'(done), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int k = 1; k <= 3 * PASS && n == 0; k++) begin
            @(posedge clk);
            #1;
            if (done) n = k;
        end
        chk("post_reset_latency", 32'(n), 32'(PASS));
        chk("post_reset_quotient", 32'(quotient), 32'd14);
        chk("post_reset_remainder", 32'(remainder), 32'd2);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
